// File: rtl/wide_add_sequencer_pkg.sv
// Shared definitions for the multi-precision adder sequencer: FSM encoding and
// the default slice width.
package wide_add_sequencer_pkg;

  localparam int W_DEFAULT = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/CSA_64bit.sv
// W-bit carry-select adder: the low half ripples, and the high half is computed
// for both carry-in values and then selected by the low-half carry.
module CSA_64bit #(
  parameter int W = 64
) (
  input  logic [W-1:0] X,
  input  logic [W-1:0] Y,
  input  logic         Cin,
  output logic [W-1:0] Sum,
  output logic         Cout
);

  localparam int LO = W / 2;
  localparam int HI = W - LO;

  logic [LO:0] lo_sum;
  logic [HI:0] hi_sum0;
  logic [HI:0] hi_sum1;

  assign lo_sum  = {1'b0, X[LO-1:0]} + {1'b0, Y[LO-1:0]} + {{LO{1'b0}}, Cin};
  assign hi_sum0 = {1'b0, X[W-1:LO]} + {1'b0, Y[W-1:LO]};
  assign hi_sum1 = {1'b0, X[W-1:LO]} + {1'b0, Y[W-1:LO]} + {{HI{1'b0}}, 1'b1};

  assign Sum  = {(lo_sum[LO] ? hi_sum1[HI-1:0] : hi_sum0[HI-1:0]), lo_sum[LO-1:0]};
  assign Cout = lo_sum[LO] ? hi_sum1[HI] : hi_sum0[HI];

endmodule

// File: rtl/wide_add_sequencer.sv
// Multi-precision adder: sums two WORDS*W-bit operands through one shared W-bit
// carry-select slice, least-significant word first, one word per cycle.
module wide_add_sequencer
  import wide_add_sequencer_pkg::*;
#(
  parameter int W     = W_DEFAULT,
  parameter int WORDS = 4,
  parameter int CNT_W = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W*WORDS-1:0] A,
  input  logic [W*WORDS-1:0] B,
  input  logic               cin,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W*WORDS-1:0] Sum,
  output logic               Cout,
  output logic               busy
);

  localparam int N = W * WORDS;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [N-1:0]     op_a_q, op_a_d;
  logic [N-1:0]     op_b_q, op_b_d;
  logic [N-1:0]     sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             out_valid_q, out_valid_d;

  logic [W-1:0]     slice_x, slice_y, slice_s;
  logic             slice_c;

  assign slice_x = op_a_q[idx_q*W +: W];
  assign slice_y = op_b_q[idx_q*W +: W];

  CSA_64bit #(.W(W)) u_slice (
    .X    (slice_x),
    .Y    (slice_y),
    .Cin  (carry_q),
    .Sum  (slice_s),
    .Cout (slice_c)
  );

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case leaves
    // a variable unassigned, which is what keeps this block from inferring latches.
    state_d     = state_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_a_d  = A;
          op_b_d  = B;
          carry_d = cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[idx_q*W +: W] = slice_s;
        carry_d             = slice_c;
        if (idx_q == LAST_IDX) begin
          idx_d       = '0;
          cout_d      = slice_c;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        // Acceptance is only possible from IDLE, so a coincident in_valid waits a cycle.
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the operand and result registers are reset too, so an aborted operation
  // leaves no stale words visible on Sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign Sum       = sum_q;
  assign Cout      = cout_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Randomized self-checking bench for wide_add_sequencer against a flat N-bit
// arithmetic reference, including stalls, back-to-back ops and mid-run reset.
module tb_wide_add_sequencer;

  localparam int W     = 64;
  localparam int WORDS = 4;
  localparam int N     = W * WORDS;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] A, B;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] Sum;
  logic         Cout;
  logic         busy;

  int errors = 0;
  int checks = 0;

  wide_add_sequencer #(.W(W), .WORDS(WORDS), .CNT_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Sum       (Sum),
    .Cout      (Cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [N:0] got, input logic [N:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] rand_n();
    logic [N-1:0] r;
    int mode;
    mode = $urandom_range(0, 7);
    for (int i = 0; i < N / 32; i++) r[i*32 +: 32] = $urandom;
    if (mode == 0) r = '1;
    else if (mode == 1) r = '0;
    else if (mode == 2) r[W-1:0] = '1;
    return r;
  endfunction

  // Full transaction: accept, latency, result, DONE hold with stalls, release.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic c,
                        input int stall);
    logic [N:0] exp;
    int n;
    exp = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c};

    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("accept_ready", in_ready, 1);

    A = a; B = b; cin = c; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    A = rand_n(); B = rand_n(); cin = ~c;

    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("latency", n, WORDS);
    check("result", {Cout, Sum}, exp);
    check("done_busy", busy, 1);
    check("done_in_ready", in_ready, 0);

    for (int s = 0; s < stall; s++) begin
      in_valid = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      check("hold_result", {Cout, Sum}, exp);
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
    end

    in_valid  = 1'($urandom_range(0, 1));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("taken_valid", out_valid, 0);
    check("taken_busy", busy, 0);
    check("taken_in_ready", in_ready, 1);
  endtask

  initial begin
    logic [N-1:0] a_v, b_v;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; cin = 1'b0;
    #22;
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", {Cout, Sum}, '0);
    check("rst_busy", busy, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", in_ready, 1);

    // in_valid without an accept would show up as busy; here it is accepted normally
    run_op('1, {{(N-1){1'b0}}, 1'b1}, 1'b0, 0);
    a_v = '0; a_v[W-1:0] = '1;
    run_op(a_v, {{(N-1){1'b0}}, 1'b1}, 1'b0, 1);
    run_op('0, '0, 1'b1, 0);
    run_op('0, '0, 1'b0, 0);
    run_op(rand_n(), rand_n(), 1'b1, 3);

    // Reset while RUN has written words 0 and 1 (idx==2).
    a_v = rand_n(); b_v = rand_n();
    A = a_v; B = b_v; cin = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_valid", out_valid, 0);
    check("abort_sum", {Cout, Sum}, '0);
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 1);
    @(negedge clk); rst_n = 1'b1;
    run_op(a_v, b_v, 1'b1, 0);

    for (int i = 0; i < 1000; i++) begin
      run_op(rand_n(), rand_n(), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
